// File: rtl/axis_dwn_pkg.sv
// Shared types, default widths and helper functions for the axis_dwn_fifo
// downsizing stream buffer.
package axis_dwn_pkg;

  localparam int IN_W_DEF   = 512;
  localparam int OUT_W_DEF  = 64;
  localparam int DEPTH_DEF  = 16;
  // Widest input keep vector the lane-search helper can scan (IN_W up to 2048).
  localparam int KEEP_MAX_W = 256;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SER  = 1'b1
  } dwn_state_e;

  function automatic int ptr_w_f(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int occ_w_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lane_w_f(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Highest lane owning a set keep bit; lane 0 when keep is all zero.
  function automatic int last_lane_f(input logic [KEEP_MAX_W-1:0] keep,
                                     input int ratio, input int lane_kb);
    int lane;
    lane = 0;
    for (int b = 0; b < KEEP_MAX_W; b++) begin
      if (keep[b] && ((b / lane_kb) < ratio)) begin
        lane = b / lane_kb;
      end else begin
        lane = lane;
      end
    end
    return lane;
  endfunction

endpackage

// File: rtl/axis_dwn_ram.sv
// Simple dual-port storage for wide FIFO entries with a registered,
// write-first read port.
module axis_dwn_ram
  import axis_dwn_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = 8
) (
  input  logic                      clk_main_a0,
  input  logic                      we,
  input  logic [ptr_w_f(DEPTH)-1:0] waddr,
  input  logic [W-1:0]              wdata,
  input  logic [ptr_w_f(DEPTH)-1:0] raddr,
  output logic [W-1:0]              rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Storage array write port.
  always_ff @(posedge clk_main_a0) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; a same-cycle write to the read address is forwarded so a
  // freshly written head entry is visible on the next cycle.
  always_ff @(posedge clk_main_a0) begin
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/axis_dwn_fifo.sv
// Wide-to-narrow AXI-Stream FIFO: stores IN_W beats, emits OUT_W lanes up to the
// last populated lane. Define AXIS_DWN_STATS_EN to add pkt_cnt/beat_cnt outputs.
module axis_dwn_fifo
  import axis_dwn_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [IN_W-1:0]          s_tdata,
  input  logic [IN_W/8-1:0]        s_tkeep,
  input  logic                     s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [OUT_W-1:0]         m_tdata,
  output logic [OUT_W/8-1:0]       m_tkeep,
  output logic                     m_tlast,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef AXIS_DWN_STATS_EN
 ,output logic [31:0]              pkt_cnt,
  output logic [31:0]              beat_cnt
`endif
);

  localparam int RATIO   = IN_W / OUT_W;
  localparam int KEEP_W  = IN_W / 8;
  localparam int LKEEP_W = OUT_W / 8;
  localparam int PTR_W   = ptr_w_f(DEPTH);
  localparam int OCC_W   = occ_w_f(DEPTH);
  localparam int LANE_W  = lane_w_f(RATIO);
  localparam int ENT_W   = IN_W + KEEP_W + 1;

  dwn_state_e        state_r, state_s;
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, rd_ptr_s;
  logic [OCC_W-1:0]  occ_r, occ_s;
  logic [LANE_W-1:0] idx_r, idx_s, last_lane_s;
  logic              push_s, pop_s, hs_s, valid_s;
  logic [ENT_W-1:0]  wr_ent_s, rd_ent_s;
  logic [IN_W-1:0]   head_data_s;
  logic [KEEP_W-1:0] head_keep_s;
  logic              head_last_s;

  assign wr_ent_s = {s_tlast, s_tkeep, s_tdata};
  assign {head_last_s, head_keep_s, head_data_s} = rd_ent_s;

  assign s_tready    = (occ_r < OCC_W'(DEPTH)) && !rst_main;
  // Empty-keep beats only matter when they close a packet.
  assign push_s      = s_tvalid && s_tready && ((|s_tkeep) || s_tlast);
  assign valid_s     = (state_r == ST_SER) && !rst_main;
  assign hs_s        = valid_s && m_tready;
  assign last_lane_s = LANE_W'(last_lane_f(KEEP_MAX_W'(head_keep_s), RATIO, LKEEP_W));
  assign pop_s       = hs_s && (idx_r == last_lane_s);
  assign m_tvalid    = valid_s;
  assign occupancy   = occ_r;

  // Read address follows the post-pop pointer so the next head is ready with no bubble.
  axis_dwn_ram #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_ram (
    .clk_main_a0 (clk_main_a0),
    .we          (push_s),
    .waddr       (wr_ptr_r),
    .wdata       (wr_ent_s),
    .raddr       (rd_ptr_s),
    .rdata       (rd_ent_s)
  );

  // Next-state logic for pointers, occupancy, lane index and serialiser FSM.
  always_comb begin
    occ_s    = occ_r;
    rd_ptr_s = rd_ptr_r;
    idx_s    = idx_r;
    state_s  = state_r;

    if (push_s && !pop_s) begin
      occ_s = occ_r + OCC_W'(1);
    end else if (!push_s && pop_s) begin
      occ_s = occ_r - OCC_W'(1);
    end else begin
      occ_s = occ_r;
    end

    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_W'(1);
      idx_s    = LANE_W'(0);
    end else if (hs_s) begin
      idx_s    = idx_r + LANE_W'(1);
    end else begin
      idx_s    = idx_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (occ_r != OCC_W'(0)) begin
          state_s = ST_SER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SER: begin
        if (pop_s && (occ_s == OCC_W'(0))) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SER;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      state_r  <= ST_IDLE;
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      occ_r    <= OCC_W'(0);
      idx_r    <= LANE_W'(0);
    end else begin
      state_r  <= state_s;
      wr_ptr_r <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
      rd_ptr_r <= rd_ptr_s;
      occ_r    <= occ_s;
      idx_r    <= idx_s;
    end
  end

  // Lane mux from the registered head entry; forced to zero when not presenting.
  always_comb begin
    m_tdata = {OUT_W{1'b0}};
    m_tkeep = {LKEEP_W{1'b0}};
    m_tlast = 1'b0;
    if (valid_s) begin
      m_tdata = head_data_s[int'(idx_r)*OUT_W +: OUT_W];
      m_tkeep = head_keep_s[int'(idx_r)*LKEEP_W +: LKEEP_W];
      m_tlast = head_last_s && (idx_r == last_lane_s);
    end else begin
      m_tdata = {OUT_W{1'b0}};
      m_tkeep = {LKEEP_W{1'b0}};
      m_tlast = 1'b0;
    end
  end

`ifdef AXIS_DWN_STATS_EN
  // Packet and narrow-beat counters, wrapping at 2^32.
  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      pkt_cnt  <= 32'd0;
      beat_cnt <= 32'd0;
    end else begin
      pkt_cnt  <= (hs_s && m_tlast) ? (pkt_cnt + 32'd1) : pkt_cnt;
      beat_cnt <= hs_s ? (beat_cnt + 32'd1) : beat_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_axis_dwn_fifo.sv
// Scoreboard bench for axis_dwn_fifo (512 -> 64, depth 16); stats checks are
// built when AXIS_DWN_STATS_EN is defined.
module tb_axis_dwn_fifo;

  localparam int IN_W  = 512;
  localparam int OUT_W = 64;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } nb_t;

  logic              clk_main_a0 = 1'b0;
  logic              rst_main;
  logic              s_tvalid, s_tready, s_tlast;
  logic [IN_W-1:0]   s_tdata;
  logic [IN_W/8-1:0] s_tkeep;
  logic              m_tvalid, m_tready, m_tlast;
  logic [OUT_W-1:0]  m_tdata;
  logic [7:0]        m_tkeep;
  logic [4:0]        occupancy;
`ifdef AXIS_DWN_STATS_EN
  logic [31:0]       pkt_cnt, beat_cnt;
`endif

  nb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  hs_cnt   = 0;

  always #5 clk_main_a0 = ~clk_main_a0;

  axis_dwn_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk_main_a0 (clk_main_a0),
    .rst_main    (rst_main),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tlast     (s_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tkeep     (m_tkeep),
    .m_tlast     (m_tlast),
    .occupancy   (occupancy)
`ifdef AXIS_DWN_STATS_EN
   ,.pkt_cnt     (pkt_cnt),
    .beat_cnt    (beat_cnt)
`endif
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every output handshake is compared against the scoreboard head.
  always @(negedge clk_main_a0) begin
    if (!rst_main && m_tvalid && m_tready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got data %0h expected no beat", m_tdata);
      end else begin
        nb_t e;
        e = sb.pop_front();
        check("beat", {7'd0, m_tlast, m_tkeep, m_tdata}, {7'd0, e});
      end
    end
  end

  function automatic logic [IN_W-1:0] mk_data(input int base);
    logic [IN_W-1:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = 64'(base + i);
    return d;
  endfunction

  // Expected narrow beats for a contiguous keep: lanes 0 .. (bytes-1)/8.
  task automatic expect_beat(input logic [IN_W-1:0] d, input logic [63:0] k, input logic l);
    int nbytes, ll;
    nb_t e;
    nbytes = $countones(k);
    ll = (nbytes == 0) ? 0 : (nbytes - 1) / 8;
    if (k != 64'd0 || l) begin
      for (int i = 0; i <= ll; i++) begin
        e.last = l && (i == ll);
        e.keep = k[i*8 +: 8];
        e.data = d[i*64 +: 64];
        sb.push_back(e);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [IN_W-1:0] d, input logic [63:0] k, input logic l);
    int w;
    w = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    while (!s_tready && w < 1000) begin
      @(posedge clk_main_a0); #1; w++;
    end
    if (!s_tready) begin
      n_checks++;
      $display("FAIL send_timeout: got s_tready 0 expected 1");
    end else begin
      @(posedge clk_main_a0); #1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_exp(input logic [IN_W-1:0] d, input logic [63:0] k, input logic l);
    expect_beat(d, k, l);
    send(d, k, l);
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while ((sb.size() != 0 || m_tvalid) && w < 2000) begin
      @(posedge clk_main_a0); #1; w++;
    end
    if (w >= 2000) begin
      n_checks++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_m_tvalid"},  80'(m_tvalid),  80'd0);
    check({name, "_m_tdata"},   80'(m_tdata),   80'd0);
    check({name, "_m_tkeep"},   80'(m_tkeep),   80'd0);
    check({name, "_m_tlast"},   80'(m_tlast),   80'd0);
    check({name, "_occupancy"}, 80'(occupancy), 80'd0);
    check({name, "_s_tready"},  80'(s_tready),  80'd0);
  endtask

  initial begin
    logic [IN_W-1:0] d;
    int start, w;
    rst_main = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    m_tready = 1'b0;
    repeat (2) @(posedge clk_main_a0);
    #1;
    check_reset_outputs("reset");
    rst_main = 1'b0;
    #1;
    check("s_tready_after_reset", 80'(s_tready), 80'd1);
    @(posedge clk_main_a0); #1;

    // 1. Full packet, latency check.
    m_tready = 1'b1;
    d = mk_data(32'h1000);
    send_exp(d, {64{1'b1}}, 1'b1);
    check("t1_valid_at_accept", 80'(m_tvalid), 80'd0);
    @(posedge clk_main_a0); #1;
    check("t1_valid_next", 80'(m_tvalid), 80'd1);
    check("t1_first_data", 80'(m_tdata), 80'h1000);
    wait_drain("t1");

    // 2. Partial last beat: 20 bytes -> keeps FF, FF, 0F.
    d = mk_data(32'h2000);
    send_exp(d, 64'h0000_0000_000F_FFFF, 1'b1);
    wait_drain("t2");
    check("t2_occupancy", 80'(occupancy), 80'd0);

    // 3. Fill under backpressure, then zero-bubble drain.
    m_tready = 1'b0;
    for (int b = 0; b < 16; b++) begin
      d = mk_data(32'h3000 + b * 16);
      send_exp(d, {64{1'b1}}, (b % 2) == 1);
    end
    check("t3_occupancy_full", 80'(occupancy), 80'd16);
    check("t3_s_tready_full", 80'(s_tready), 80'd0);
    s_tdata = mk_data(32'h3F00); s_tkeep = {64{1'b1}}; s_tlast = 1'b1; s_tvalid = 1'b1;
    repeat (3) @(posedge clk_main_a0);
    #1;
    check("t3_17th_blocked", 80'(s_tready), 80'd0);
    check("t3_occupancy_held", 80'(occupancy), 80'd16);
    check("t3_head_valid", 80'(m_tvalid), 80'd1);
    s_tvalid = 1'b0;
    start = hs_cnt;
    m_tready = 1'b1;
    repeat (128) @(posedge clk_main_a0);
    #1;
    check("t3_beats_in_128_cycles", 80'(hs_cnt - start), 80'd128);
    check("t3_occupancy_empty", 80'(occupancy), 80'd0);
    check("t3_valid_after_drain", 80'(m_tvalid), 80'd0);

    // 4. Zero-keep beats.
    d = mk_data(32'h4000);
    send_exp(d, 64'd0, 1'b0);
    check("t4_discard_occupancy", 80'(occupancy), 80'd0);
    repeat (3) @(posedge clk_main_a0);
    #1;
    check("t4_discard_no_valid", 80'(m_tvalid), 80'd0);
    d = mk_data(32'hDEAD);
    send_exp(d, 64'd0, 1'b1);
    wait_drain("t4");

    // 5. Reset after three lanes of a packet.
    d = mk_data(32'h5000);
    start = hs_cnt;
    send_exp(d, {64{1'b1}}, 1'b1);
    w = 0;
    while ((hs_cnt - start) < 3 && w < 100) begin
      @(posedge clk_main_a0); #1; w++;
    end
    check("t5_lanes_before_reset", 80'(hs_cnt - start), 80'd3);
    rst_main = 1'b1;
    sb.delete();
    @(posedge clk_main_a0); #1;
    check_reset_outputs("t5");
    rst_main = 1'b0;
    #1;
    check("t5_s_tready_after", 80'(s_tready), 80'd1);
    @(posedge clk_main_a0); #1;
    d = mk_data(32'h5100);
    send_exp(d, {64{1'b1}}, 1'b1);
    wait_drain("t5");

`ifdef AXIS_DWN_STATS_EN
    // 6. Four two-beat packets.
    rst_main = 1'b1;
    @(posedge clk_main_a0); #1;
    rst_main = 1'b0;
    for (int p = 0; p < 4; p++) begin
      send_exp(mk_data(32'h6000 + p * 32), {64{1'b1}}, 1'b0);
      send_exp(mk_data(32'h6010 + p * 32), {64{1'b1}}, 1'b1);
    end
    wait_drain("t6");
    check("t6_pkt_cnt", 80'(pkt_cnt), 80'd4);
    check("t6_beat_cnt", 80'(beat_cnt), 80'd64);
`endif

    check("sb_empty_at_end", 80'(sb.size()), 80'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_dwn_fifo.md
Name: axis_dwn_fifo

Overview:
Parametrised downsizing stream buffer. It accepts wide AXI-Stream beats (default 512b from the DMA PCIS write path), stores them in a DEPTH-entry FIFO, and serialises each entry into narrow beats (default 64b) for the compute datapath.
It supersedes the fixed 512-to-64 converter plus separate 64b FIFO pair. It adds tkeep/tlast packet handling, trailing-lane skipping, zero-bubble throughput and an occupancy output.

Parameters:
IN_W, 512, input data width in bits; must equal OUT_W * 2^k with k>=1
OUT_W, 64, output data width in bits; multiple of 8
DEPTH, 16, FIFO depth in wide entries, including the entry currently being serialised; power of 2, >=2

Ports:
clk_main_a0  in  1  clock; single clock domain
rst_main  in  1  reset, synchronous, active-high
s_tvalid  in  1  input beat valid
s_tready  out  1  input ready
s_tdata  in  IN_W  input data
s_tkeep  in  IN_W/8  input byte enables; contiguous from LSB
s_tlast  in  1  input end of packet
m_tvalid  out  1  output beat valid
m_tready  in  1  output ready
m_tdata  out  OUT_W  output data
m_tkeep  out  OUT_W/8  output byte enables
m_tlast  out  1  output end of packet
occupancy  out  $clog2(DEPTH)+1  stored wide entries, including the head entry

Behaviour:
- Reset: clk_main_a0 is the only clock. rst_main is synchronous and active-high. While rst_main=1: s_tready=0, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, occupancy=0, lane index=0. s_tready rises in the first cycle after reset deasserts.
- Parameter derivation: RATIO=IN_W/OUT_W. Narrow lane i is bits [i*OUT_W +: OUT_W] and keep bits [i*OUT_W/8 +: OUT_W/8]. Lane 0 is emitted first (little-endian).
- Input side:
  - s_tready = (occupancy < DEPTH) && !rst_main.
  - A beat is accepted on s_tvalid && s_tready.
  - An accepted beat with s_tkeep==0 and s_tlast==0 is discarded: no write, occupancy unchanged.
  - An accepted beat with s_tkeep==0 and s_tlast==1 is stored.
- Output FSM:
  - IDLE: no head entry; m_tvalid=0. Moves to SER when occupancy becomes nonzero.
  - SER: m_tvalid=1, and the outputs present lane idx of the head entry.
- Lane selection:
  - last_lane = highest lane with a nonzero keep slice; 0 if the whole keep is 0.
  - m_tlast = head.last && (idx == last_lane).
  - Lanes above last_lane are never emitted, for last and non-last entries alike.
- Output handshake (m_tvalid && m_tready):
  - If idx==last_lane: pop the head, set idx=0, and load the next entry in the same cycle with no bubble. Stay in SER if another entry exists, otherwise go to IDLE.
  - Otherwise idx++.
- Output stability: m_tdata, m_tkeep and m_tlast hold stable while m_tvalid && !m_tready.
- Latency: a write accepted at edge N into an empty block gives m_tvalid=1 after edge N+1.
- Throughput: sustained one narrow beat per cycle.
- Occupancy arithmetic: simultaneous push and pop leave occupancy unchanged. Push while full is impossible because s_tready=0. Pop on empty is impossible.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset mid-packet: all stored data is discarded. The next accepted beat begins at lane 0 with no residual tlast state.
- Keep contiguity: non-contiguous s_tkeep is a protocol violation. last_lane still follows the highest nonzero slice.

Optional Feature:
AXIS_DWN_STATS_EN
- Defined: adds output ports pkt_cnt[31:0] and beat_cnt[31:0].
  - pkt_cnt increments on each m_tlast handshake.
  - beat_cnt increments on each m_tvalid && m_tready.
  - Both wrap at 2^32 and clear on rst_main.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package axis_dwn_pkg holds:
  - function last_lane_f(keep, RATIO), which returns the lane index;
  - function clog2-based width helpers;
  - localparam default widths IN_W_DEF=512, OUT_W_DEF=64, DEPTH_DEF=16.
- Sub-module axis_dwn_ram: simple dual-port storage, DEPTH x (IN_W + IN_W/8 + 1), registered read. The top level owns the pointers, occupancy, FSM and lane mux.

Test Plan:
All scenarios use IN_W=512, OUT_W=64, DEPTH=16.
1. Full packet: one beat, keep=all-ones, last=1, lane i data=64'h1000+i, m_tready=1 -> 8 beats with data 0x1000..0x1007, keep 0xFF. m_tlast only on the 8th beat. First m_tvalid one cycle after accept.
2. Partial last beat: keep=20 bytes, last=1 -> 3 beats with keep 0xFF, 0xFF, 0x0F; m_tlast on the 3rd beat; lanes 3..7 never emitted.
3. Backpressure fill: m_tready=0, offer 17 beats -> 16 accepted, s_tready=0, occupancy=16. Then set m_tready=1 -> 128 narrow beats in order with no idle cycles; occupancy returns to 0.
4. Zero-keep handling: keep=0/last=0 -> nothing emitted, occupancy stays 0. Then keep=0/last=1 -> one beat with keep=0x00, m_tlast=1.
5. Reset mid-packet: assert rst_main after 3 of 8 lanes emitted -> outputs 0 and occupancy 0. After reset, a new full beat emits from lane 0.
6. Stats (AXIS_DWN_STATS_EN defined): 4 packets of 2 full beats each -> pkt_cnt=4, beat_cnt=64.
